// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types for the MEM/WB pipeline stage.
//   - wb_sel_e         : write-back source select (mem_to_reg)
//   - MEM_WB_NBITS     : default datapath width
//   - MEM_WB_REG_ADDR_W: default register-file address width
//   - mem_wb_payload_t : MEM/WB payload at the default widths, for stages that
//                        exchange the payload as a single packed value
package mem_wb_pkg;

  localparam int unsigned MEM_WB_NBITS      = 32;
  localparam int unsigned MEM_WB_REG_ADDR_W = 5;

  // WB_RSVD is decoded like WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic [MEM_WB_NBITS-1:0]      pc_4;
    logic [MEM_WB_NBITS-1:0]      alu_result;
    logic [MEM_WB_NBITS-1:0]      read_data;
    logic [MEM_WB_REG_ADDR_W-1:0] write_register;
    logic                         reg_write;
    wb_sel_e                      mem_to_reg;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_stage_pipe_skid_buffer.sv
// pipe_skid_buffer: generic ready/valid pipeline register of W bits.
// Build option MEM_WB_SKID_EN adds a second (skid) entry so that in_ready is
// a flop with no combinational path from out_ready.
// Ports:
//   clk, reset (sync, active-high), flush (sync squash of held entries)
//   in_valid/in_ready/in_data   : upstream handshake and payload
//   out_valid/out_ready/out_data: downstream handshake and payload (from M)
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | M and S empty
// ST_ONE   | M holds the output payload, S empty
// ST_FULL  | M and S both full, in_ready low (skid build only)
module pipe_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

`ifdef MEM_WB_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;
`else
  typedef enum logic {ST_EMPTY = 1'b0, ST_ONE = 1'b1} state_e;
`endif

  state_e       state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic         accept;
  logic         drain;

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_q;

`ifdef MEM_WB_SKID_EN
  logic [W-1:0] s_q, s_d;
  logic         ready_q;

  assign in_ready = ready_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          m_d = in_data;
        end else if (accept) begin
          s_d     = in_data;
          state_d = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash drops the incoming beat too; stale payload bits are harmless
    // because out_valid is low.
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ready_q <= (state_d != ST_FULL);
    end
  end
`else
  // With one entry, a full M can only reload when it drains in the same cycle.
  assign in_ready = out_ready || !out_valid;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    if (accept) begin
      m_d     = in_data;
      state_d = ST_ONE;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with ready/valid handshake,
// synchronous flush, write-back data mux and EX-stage forwarding port.
// Build option: MEM_WB_SKID_EN selects the two-entry skid buffer (registered
// in_ready); without it a single register with combinational in_ready is used.
// Ports:
//   clk, reset (sync, active-high), flush (sync squash)
//   in_*  : MEM-stage payload and in_valid/in_ready handshake
//   out_* : held payload and out_valid/out_ready handshake
//   wb_data                        : selected write-back value
//   fwd_valid/fwd_register/fwd_data: bypass source for the EX stage
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned NBITS      = MEM_WB_NBITS,
  parameter int unsigned REG_ADDR_W = MEM_WB_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBITS-1:0]      in_pc_4,
  input  logic [NBITS-1:0]      in_alu_result,
  input  logic [NBITS-1:0]      in_read_data,
  input  logic [REG_ADDR_W-1:0] in_write_register,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBITS-1:0]      out_pc_4,
  output logic [NBITS-1:0]      out_alu_result,
  output logic [NBITS-1:0]      out_read_data,
  output logic [REG_ADDR_W-1:0] out_write_register,
  output logic                  out_reg_write,
  output logic [1:0]            out_mem_to_reg,
  output logic [NBITS-1:0]      wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_register,
  output logic [NBITS-1:0]      fwd_data
);

  // Same layout as mem_wb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [NBITS-1:0]      pc_4;
    logic [NBITS-1:0]      alu_result;
    logic [NBITS-1:0]      read_data;
    logic [REG_ADDR_W-1:0] write_register;
    logic                  reg_write;
    wb_sel_e               mem_to_reg;
  } payload_t;

  payload_t in_pl;
  payload_t out_pl;

  assign in_pl = '{
    pc_4:           in_pc_4,
    alu_result:     in_alu_result,
    read_data:      in_read_data,
    write_register: in_write_register,
    reg_write:      in_reg_write,
    mem_to_reg:     wb_sel_e'(in_mem_to_reg)
  };

  pipe_skid_buffer #(
    .W($bits(payload_t))
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl)
  );

  assign out_pc_4           = out_pl.pc_4;
  assign out_alu_result     = out_pl.alu_result;
  assign out_read_data      = out_pl.read_data;
  assign out_write_register = out_pl.write_register;
  assign out_mem_to_reg     = out_pl.mem_to_reg;
  // A flushed entry may leave reg_write set in M; never expose it as a write.
  assign out_reg_write      = out_pl.reg_write && out_valid;

  always_comb begin
    wb_data = out_pl.alu_result;
    case (out_pl.mem_to_reg)
      WB_MEM:  wb_data = out_pl.read_data;
      WB_PC4:  wb_data = out_pl.pc_4;
      default: wb_data = out_pl.alu_result;
    endcase
  end

  // x0 is hard-wired zero, so writes to it must never be bypassed.
  assign fwd_valid    = out_reg_write && (out_pl.write_register != '0);
  assign fwd_register = out_pl.write_register;
  assign fwd_data     = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        rw;
    logic [1:0]  m2r;
  } pl_t;

  typedef struct {
    logic [1:0]  m2r;
    logic [4:0]  wr;
    logic        rw;
    logic [31:0] exp_wb;
    logic        exp_fwd;
  } vec_t;

`ifdef MEM_WB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  pl_t         cur_in;
  logic        in_ready, out_valid, out_reg_write, fwd_valid;
  logic [31:0] out_pc_4, out_alu_result, out_read_data, wb_data, fwd_data;
  logic [4:0]  out_write_register, fwd_register;
  logic [1:0]  out_mem_to_reg;

  int          n_tests = 0;
  int          n_fail  = 0;
  pl_t         mq[$];
  pl_t         txq[$];
  logic [31:0] delivered[$];
  bit          use_txq;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc_4           (cur_in.pc_4),
    .in_alu_result     (cur_in.alu),
    .in_read_data      (cur_in.rd),
    .in_write_register (cur_in.wr),
    .in_reg_write      (cur_in.rw),
    .in_mem_to_reg     (cur_in.m2r),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc_4          (out_pc_4),
    .out_alu_result    (out_alu_result),
    .out_read_data     (out_read_data),
    .out_write_register(out_write_register),
    .out_reg_write     (out_reg_write),
    .out_mem_to_reg    (out_mem_to_reg),
    .wb_data           (wb_data),
    .fwd_valid         (fwd_valid),
    .fwd_register      (fwd_register),
    .fwd_data          (fwd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_wb(input pl_t p);
    case (p.m2r)
      2'd1:    return p.rd;
      2'd2:    return p.pc_4;
      default: return p.alu;
    endcase
  endfunction

  function automatic bit ref_in_ready();
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic pl_t mk(input logic [31:0] alu, input logic [1:0] m2r,
                             input logic [4:0] wr, input logic rw);
    pl_t p;
    p.pc_4 = 32'h400;
    p.alu  = alu;
    p.rd   = 32'hDEAD;
    p.wr   = wr;
    p.rw   = rw;
    p.m2r  = m2r;
    return p;
  endfunction

  task automatic check_outputs();
    pl_t f;
    chk("in_ready", 32'(in_ready), 32'(ref_in_ready()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      f = mq[0];
      chk("out_pc_4", out_pc_4, f.pc_4);
      chk("out_alu_result", out_alu_result, f.alu);
      chk("out_read_data", out_read_data, f.rd);
      chk("out_write_register", 32'(out_write_register), 32'(f.wr));
      chk("out_reg_write", 32'(out_reg_write), 32'(f.rw));
      chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(f.m2r));
      chk("wb_data", wb_data, ref_wb(f));
      chk("fwd_valid", 32'(fwd_valid), 32'(f.rw && (f.wr != 5'd0)));
      chk("fwd_register", 32'(fwd_register), 32'(f.wr));
      chk("fwd_data", fwd_data, ref_wb(f));
    end else begin
      chk("out_reg_write idle", 32'(out_reg_write), 32'd0);
      chk("fwd_valid idle", 32'(fwd_valid), 32'd0);
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle(input bit do_chk);
    bit acc, drn;
    if (use_txq) begin
      in_valid = (txq.size() != 0);
      if (txq.size() != 0) cur_in = txq[0];
    end
    #1;
    if (do_chk) check_outputs();
    acc = in_valid && ref_in_ready();
    drn = (mq.size() != 0) && out_ready;
    if (drn && !reset && !flush) delivered.push_back(out_alu_result);
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(cur_in);
    end
    if (use_txq && acc) void'(txq.pop_front());
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " out_pc_4"}, out_pc_4, 32'd0);
    chk({tag, " out_alu_result"}, out_alu_result, 32'd0);
    chk({tag, " out_read_data"}, out_read_data, 32'd0);
    chk({tag, " out_write_register"}, 32'(out_write_register), 32'd0);
    chk({tag, " out_reg_write"}, 32'(out_reg_write), 32'd0);
    chk({tag, " out_mem_to_reg"}, 32'(out_mem_to_reg), 32'd0);
    chk({tag, " wb_data"}, wb_data, 32'd0);
    chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, " fwd_data"}, fwd_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [31:0] stream_exp[3];
    logic [31:0] bp_exp[3];
    logic [31:0] rs_exp[2];

    vt[0] = '{2'd0, 5'd7, 1'b1, 32'h1234, 1'b1};
    vt[1] = '{2'd1, 5'd7, 1'b1, 32'hDEAD, 1'b1};
    vt[2] = '{2'd2, 5'd7, 1'b1, 32'h400,  1'b1};
    vt[3] = '{2'd3, 5'd7, 1'b1, 32'h1234, 1'b1};
    vt[4] = '{2'd0, 5'd0, 1'b1, 32'h1234, 1'b0};
    vt[5] = '{2'd1, 5'd9, 1'b0, 32'hDEAD, 1'b0};
    stream_exp = '{32'h10, 32'h20, 32'h30};
    bp_exp     = '{32'hA, 32'hB, 32'hC};
    rs_exp     = '{32'h71, 32'h72};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur_in = '0; use_txq = 1'b0;
    @(negedge clk);
    cycle(0);
    cycle(0);
    reset = 1'b0;
    check_zero("reset");

    // Streaming with out_ready high
    use_txq = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) txq.push_back(mk(stream_exp[i], 2'd0, 5'd1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      chk("stream wb_data", wb_data, stream_exp[i]);
      chk("stream out_valid", 32'(out_valid), 32'd1);
    end
    cycle(1);
    chk("stream idle", 32'(out_valid), 32'd0);

    // Back-pressure
    delivered.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) txq.push_back(mk(bp_exp[i], 2'd0, 5'd3, 1'b1));
    repeat (4) cycle(1);
    chk("bp in_ready", 32'(in_ready), 32'd0);
    chk("bp held", out_alu_result, 32'hA);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp pending", 32'(txq.size()), (CAP == 2) ? 32'd1 : 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 12 && (txq.size() != 0 || mq.size() != 0); i++) cycle(1);
    chk("bp drained", 32'(txq.size() + mq.size()), 32'd0);
    chk("bp count", 32'(delivered.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("bp order", (i < delivered.size()) ? delivered[i] : 32'hFFFF_FFFF, bp_exp[i]);

    // Write-back mux and forwarding table
    for (int i = 0; i < 6; i++) begin
      txq.push_back(mk(32'h1234, vt[i].m2r, vt[i].wr, vt[i].rw));
      out_ready = 1'b0;
      cycle(1);
      chk("mux out_valid", 32'(out_valid), 32'd1);
      chk("mux wb_data", wb_data, vt[i].exp_wb);
      chk("mux fwd_valid", 32'(fwd_valid), 32'(vt[i].exp_fwd));
      chk("mux fwd_register", 32'(fwd_register), 32'(vt[i].wr));
      chk("mux fwd_data", fwd_data, vt[i].exp_wb);
      out_ready = 1'b1;
      cycle(1);
    end

    // Flush while stalled, with a beat offered on the same edge
    delivered.delete();
    out_ready = 1'b0;
    txq.push_back(mk(32'h51, 2'd0, 5'd4, 1'b1));
    txq.push_back(mk(32'h52, 2'd0, 5'd4, 1'b1));
    txq.push_back(mk(32'h53, 2'd0, 5'd4, 1'b1));
    for (int i = 0; i < 6 && in_ready; i++) cycle(1);
    chk("flush stalled", 32'(in_ready), 32'd0);
    chk("flush offered", 32'(txq.size() != 0), 32'd1);
    flush = 1'b1;
    cycle(1);
    flush = 1'b0;
    txq.delete();
    in_valid = 1'b0;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush out_reg_write", 32'(out_reg_write), 32'd0);
    chk("flush fwd_valid", 32'(fwd_valid), 32'd0);
    out_ready = 1'b1;
    repeat (3) cycle(1);
    chk("flush nothing delivered", 32'(delivered.size()), 32'd0);

    // Reset while stalled, then resume streaming
    out_ready = 1'b0;
    txq.push_back(mk(32'h61, 2'd1, 5'd5, 1'b1));
    txq.push_back(mk(32'h62, 2'd1, 5'd5, 1'b1));
    txq.push_back(mk(32'h63, 2'd1, 5'd5, 1'b1));
    for (int i = 0; i < 6 && in_ready; i++) cycle(1);
    chk("rst stalled", 32'(in_ready), 32'd0);
    txq.delete();
    reset = 1'b1;
    cycle(0);
    reset = 1'b0;
    in_valid = 1'b0;
    check_zero("midreset");
    delivered.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) txq.push_back(mk(rs_exp[i], 2'd0, 5'd6, 1'b1));
    repeat (4) cycle(1);
    chk("rst resume count", 32'(delivered.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      chk("rst resume order", (i < delivered.size()) ? delivered[i] : 32'hFFFF_FFFF, rs_exp[i]);

    // Random traffic against the queue model
    use_txq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      cur_in.pc_4 = $urandom;
      cur_in.alu  = $urandom;
      cur_in.rd   = $urandom;
      cur_in.wr   = 5'($urandom_range(0, 31));
      cur_in.rw   = 1'($urandom_range(0, 1));
      cur_in.m2r  = 2'($urandom_range(0, 3));
      cycle(1);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    cycle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
